// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction RAM between the fetch
// stage and a debug/loader port. Fetch owns the RAM by default; debug gets
// idle fetch cycles, or is forced in after a starvation limit. A forced debug
// burst is capped while fetch keeps requesting.
module imem_arbiter #(
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned MAX_DBG_BURST = 4,
    parameter int unsigned STARVE_LIMIT  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_grant,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              imem_modified,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BURST_W  = $clog2(MAX_DBG_BURST + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_DBG_BURST);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_DBG   = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_DBG_RD = 2'd2,
        OWN_DBG_WR = 2'd3
    } owner_e;

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    owner_e              owner_q, owner_d;
    logic [DATA_W-1:0]   fetch_rdata_q, fetch_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

    logic                fetch_go;
    logic                dbg_go;
    logic [STARVE_W-1:0] starve_inc;
    logic [BURST_W-1:0]  burst_inc;

    // Saturating increments of the starvation and burst counters
    always_comb begin
        starve_inc = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + STARVE_W'(1);
        burst_inc  = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + BURST_W'(1);
    end

    // Arbitration FSM: decides who owns this cycle and the next state/counters
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        fetch_go     = 1'b0;
        dbg_go       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (fetch_req && !(dbg_req && (starve_cnt_q == STARVE_MAX))) begin
                    fetch_go = 1'b1;
                    if (dbg_req) begin
                        starve_cnt_d = starve_inc;
                    end
                end else if (dbg_req) begin
                    dbg_go       = 1'b1;
                    starve_cnt_d = '0;
                    burst_cnt_d  = BURST_W'(1);
                    state_d      = S_DBG;
                end
            end
            S_DBG: begin
                if (dbg_req && (!fetch_req || (burst_cnt_q < BURST_MAX))) begin
                    dbg_go      = 1'b1;
                    burst_cnt_d = burst_inc;
                end else begin
                    // Hand back to fetch without a bubble
                    state_d     = S_FETCH;
                    burst_cnt_d = '0;
                    fetch_go    = fetch_req;
                    if (fetch_req && dbg_req) begin
                        starve_cnt_d = starve_inc;
                    end
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Starvation only counts an uninterrupted pending debug request
        if (!dbg_req) begin
            starve_cnt_d = '0;
        end
    end

    // Memory-side issue: grants, address, write strobe and owner tag
    always_comb begin
        fetch_grant = 1'b0;
        dbg_grant   = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        owner_d     = OWN_NONE;
        if (!reset) begin
            fetch_grant = fetch_go;
            dbg_grant   = dbg_go;
            mem_addr    = dbg_go ? dbg_addr : fetch_addr;
            if (dbg_go) begin
                mem_we    = dbg_we;
                mem_wdata = dbg_wdata;
                owner_d   = dbg_we ? OWN_DBG_WR : OWN_DBG_RD;
            end else if (fetch_go) begin
                owner_d = OWN_FETCH;
            end
        end
    end

    // Return path: RAM data flows to the owner, the other side holds its last value
    always_comb begin
        fetch_rdata_d = fetch_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        if (owner_q == OWN_FETCH) begin
            fetch_rdata_d = mem_rdata;
        end
        if (owner_q == OWN_DBG_RD) begin
            dbg_rdata_d = mem_rdata;
        end
    end

    assign fetch_rdata   = fetch_rdata_d;
    assign dbg_rdata     = dbg_rdata_d;
    assign fetch_rvalid  = (owner_q == OWN_FETCH);
    assign dbg_rvalid    = (owner_q == OWN_DBG_RD);
    assign imem_modified = (owner_q == OWN_DBG_WR);

    // State, counters, owner tag and held read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            starve_cnt_q  <= '0;
            burst_cnt_q   <= '0;
            owner_q       <= OWN_NONE;
            fetch_rdata_q <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            owner_q       <= owner_d;
            fetch_rdata_q <= fetch_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios followed by a
// randomized request mix, checked against a cycle-level behavioural model.
module tb_imem_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int MAX_BURST = 4;
    localparam int LIMIT     = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_grant, fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_grant, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          imem_modified;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    imem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DBG_BURST(MAX_BURST), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_grant(dbg_grant), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .imem_modified(imem_modified),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 291 + 23130);
    endfunction

    // Synchronous single-port RAM, 256 words (low address bits), 1-cycle read
    logic [DW-1:0] ram [0:255];
    logic          ram_loaded = 1'b0;
    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[7:0]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state (arbiter history + expected RAM contents)
    logic [DW-1:0] ref_mem [0:255];
    int            dbg_run = 0;    // consecutive debug grants just before this cycle
    int            waited  = 0;    // consecutive denied debug-request cycles
    bit            pf = 0, pdr = 0, pdw = 0;
    logic [DW-1:0] pdata = '0;
    logic [DW-1:0] hold_f = '0, hold_d = '0;
    bit            last_fg = 0, last_dg = 0;
    logic          seen_fg, seen_dg;

    // One clock cycle: drive at negedge, check shortly after, advance model
    task automatic step(input logic rst, input logic fr, input logic [AW-1:0] fa,
                        input logic dr, input logic dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd);
        logic          dbg_wins;
        logic          e_fg;
        logic          e_we;
        logic [AW-1:0] e_addr;
        @(negedge clock);
        reset = rst; fetch_req = fr; fetch_addr = fa;
        dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
        #1;
        if (rst) begin
            pf = 0; pdr = 0; pdw = 0; hold_f = '0; hold_d = '0;
        end else begin
            if (pf)  hold_f = pdata;
            if (pdr) hold_d = pdata;
        end
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(pf));
        chk("fetch_rdata", 32'(fetch_rdata), 32'(hold_f));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(pdr));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(hold_d));
        chk("imem_modified", 32'(imem_modified), 32'(pdw));

        dbg_wins = 1'b0;
        if (!rst && dr) begin
            if (!fr)              dbg_wins = 1'b1;
            else if (dbg_run > 0) dbg_wins = (dbg_run < MAX_BURST);
            else                  dbg_wins = (waited >= LIMIT);
        end
        e_fg   = !rst && fr && !dbg_wins;
        e_addr = rst ? '0 : (dbg_wins ? da : fa);
        e_we   = dbg_wins && dwe;
        chk("fetch_grant", 32'(fetch_grant), 32'(e_fg));
        chk("dbg_grant", 32'(dbg_grant), 32'(dbg_wins));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(dwd));
        chk("one_grant", 32'(fetch_grant && dbg_grant), 32'(0));
        seen_fg = fetch_grant;
        seen_dg = dbg_grant;

        if (rst) begin
            dbg_run = 0; waited = 0;
        end else if (dbg_wins) begin
            dbg_run++; waited = 0;
        end else begin
            dbg_run = 0;
            waited  = !dr ? 0 : ((waited < LIMIT) ? waited + 1 : LIMIT);
        end
        pf  = e_fg;
        pdr = dbg_wins && !dwe;
        pdw = e_we;
        if (pf || pdr) pdata = ref_mem[e_addr[7:0]];
        if (e_we) ref_mem[da[7:0]] = dwd;
        last_fg = e_fg;
        last_dg = dbg_wins;
    endtask

    initial begin
        int            first_dbg;
        int            n_dg;
        logic          fg12;
        logic          r_fr, r_dr, r_dwe, do_rst;
        logic [AW-1:0] r_fa, r_da;
        logic [DW-1:0] r_dwd;
        int            dbg_pct, fetch_pct;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset held
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 20'h3, 1'b1, 1'b1, 20'h7, 16'h1234);

        // Fetch only, addresses 0..9
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 20'h9, 1'b0, 1'b0, '0, '0);

        // Debug read of 0x10 while fetch idle
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 20'h00010, '0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("dbg_read_0x10", 32'(dbg_rdata), 32'(init_word(16)));

        // Starvation then capped forced burst
        first_dbg = -1; n_dg = 0; fg12 = 1'b0;
        for (int c = 0; c < 13; c++) begin
            step(1'b0, 1'b1, 20'h40, 1'b1, 1'b0, 20'h33, '0);
            if (seen_dg) begin
                if (first_dbg < 0) first_dbg = c;
                n_dg++;
            end
            if (c == 12) fg12 = seen_fg;
        end
        chk("starve_first_dbg", 32'(first_dbg), 32'(8));
        chk("starve_burst_len", 32'(n_dg), 32'(4));
        chk("starve_fetch_back", 32'(fg12), 32'(1));
        step(1'b0, 1'b1, 20'h41, 1'b0, 1'b0, '0, '0);

        // Debug write 0xBEEF to 0x20, then fetch reads it back
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 20'h00020, 16'hBEEF);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("imem_mod_pulse", 32'(imem_modified), 32'(1));
        step(1'b0, 1'b1, 20'h00020, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 20'h00020, 1'b0, 1'b0, '0, '0);
        chk("fetch_reads_beef", 32'(fetch_rdata), 32'(16'hBEEF));

        // Reset in the cycle after a fetch grant
        step(1'b0, 1'b1, 20'h5, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 20'h6, 1'b1, 1'b0, 20'h30, '0);
        chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'(0));
        step(1'b0, 1'b1, 20'h7, 1'b1, 1'b0, 20'h30, '0);
        chk("post_rst_fetch_wins", 32'(seen_fg), 32'(1));
        chk("post_rst_dbg_waits", 32'(seen_dg), 32'(0));

        // Randomized request mix; requesters hold their request until granted
        r_fr = 1'b1; r_fa = 20'h8; r_dr = 1'b1; r_dwe = 1'b0; r_da = 20'h30; r_dwd = '0;
        dbg_pct = 50; fetch_pct = 75;
        for (int k = 0; k < 1500; k++) begin
            if (k % 250 == 0) begin
                dbg_pct   = int'($urandom_range(10, 90));
                fetch_pct = int'($urandom_range(50, 100));
            end
            if (!r_fr || last_fg) begin
                r_fr = (int'($urandom_range(0, 99)) < fetch_pct);
                r_fa = ($urandom_range(0, 7) == 0) ? AW'($urandom) : r_fa + AW'(1);
            end
            if (!r_dr || last_dg) begin
                r_dr  = (int'($urandom_range(0, 99)) < dbg_pct);
                r_dwe = ($urandom_range(0, 2) == 0);
                r_da  = AW'($urandom);
                r_dwd = DW'($urandom);
            end
            do_rst = ($urandom_range(0, 299) == 0);
            step(do_rst, r_fr, r_fa, r_dr, r_dwe, r_da, r_dwd);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
